clock_24: RTL and testbench



---
 rtl/clock_24_pkg.sv | 16 +
 rtl/clock_24_if.sv | 14 +
 rtl/clock_24_bcd_digit_counter.sv | 32 +++
 rtl/clock_24.sv | 72 +++++++
 tb/tb_clock_24.sv | 137 +++++++++++++
 5 files changed

// File: rtl/clock_24_pkg.sv
// rtl/clock_24_pkg.sv - shared digit limits and widths for the clock_24 time-of-day counter
// Contents: per-digit maximum values, the 23:59 wrap point and digit widths.
package clock24_pkg;

  localparam int MIN1_MAX        = 9;
  localparam int MIN10_MAX       = 5;
  localparam int HOUR1_MAX       = 9;
  localparam int HOUR_WRAP_TENS  = 2;
  localparam int HOUR_WRAP_UNITS = 3;

  localparam int MIN1_W   = 4;
  localparam int MIN10_W  = 3;
  localparam int HOUR1_W  = 4;
  localparam int HOUR10_W = 2;

endpackage

// File: rtl/clock_24_if.sv
// rtl/clock_24_if.sv - HH:MM BCD digit bundle produced by clock_24
// Signals: min1 (minutes units), min10 (minutes tens), hour1 (hours units), hour10 (hours tens).
// Modports: master drives the digits, slave observes them.
interface clock_24_if;
  import clock24_pkg::*;

  logic [MIN1_W-1:0]   min1;
  logic [MIN10_W-1:0]  min10;
  logic [HOUR1_W-1:0]  hour1;
  logic [HOUR10_W-1:0] hour10;

  modport master (output min1, output min10, output hour1, output hour10);
  modport slave  (input  min1, input  min10, input  hour1, input  hour10);
endinterface

// File: rtl/clock_24_bcd_digit_counter.sv
// rtl/clock_24_bcd_digit_counter.sv - one wrapping decimal digit of the time-of-day chain
// Ports: clk, reset (async, active-high), inc (count enable), clr (sync clear),
//        q (digit value), carry (inc while q is at its maximum).
module bcd_digit_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             carry
);

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MAX);

  // An out-of-range value is forced back to 0 on the next edge even
  // without inc, so a corrupted digit cannot persist.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr || (q > QMAX)) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == QMAX) ? '0 : q + 1'b1;
    end
  end

  assign carry = inc && (q == QMAX);

endmodule

// File: rtl/clock_24.sv
// rtl/clock_24.sv - free-running 24-hour HH:MM counter, one minute per clk edge
// Ports: clk (one rising edge = one minute), reset (async, active-high, forces 00:00),
//        tod (clock_24_if master: min1, min10, hour1, hour10 straight from flops).
module clock_24
  import clock24_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  clock_24_if.master      tod
);

  logic [MIN1_W-1:0]   min1_q;
  logic [MIN10_W-1:0]  min10_q;
  logic [HOUR1_W-1:0]  hour1_q;
  logic [HOUR10_W-1:0] hour10_q;

  logic min1_carry;
  logic min10_carry;
  logic hour1_carry;
  logic hour10_carry;
  logic hour_clr;

  // Wrap 23:59 -> 00:00 by clearing both hour digits on the hour carry out
  // of 23. An hour10 overflow can only come from a corrupted state and is
  // folded into the same clear.
  assign hour_clr = (min10_carry
                     && (hour10_q == HOUR10_W'(HOUR_WRAP_TENS))
                     && (hour1_q  == HOUR1_W'(HOUR_WRAP_UNITS)))
                    || hour10_carry;

  bcd_digit_counter #(.WIDTH(MIN1_W), .MAX(MIN1_MAX)) u_min1 (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .clr   (1'b0),
    .q     (min1_q),
    .carry (min1_carry)
  );

  bcd_digit_counter #(.WIDTH(MIN10_W), .MAX(MIN10_MAX)) u_min10 (
    .clk   (clk),
    .reset (reset),
    .inc   (min1_carry),
    .clr   (1'b0),
    .q     (min10_q),
    .carry (min10_carry)
  );

  bcd_digit_counter #(.WIDTH(HOUR1_W), .MAX(HOUR1_MAX)) u_hour1 (
    .clk   (clk),
    .reset (reset),
    .inc   (min10_carry),
    .clr   (hour_clr),
    .q     (hour1_q),
    .carry (hour1_carry)
  );

  bcd_digit_counter #(.WIDTH(HOUR10_W), .MAX(HOUR_WRAP_TENS)) u_hour10 (
    .clk   (clk),
    .reset (reset),
    .inc   (hour1_carry),
    .clr   (hour_clr),
    .q     (hour10_q),
    .carry (hour10_carry)
  );

  assign tod.min1   = min1_q;
  assign tod.min10  = min10_q;
  assign tod.hour1  = hour1_q;
  assign tod.hour10 = hour10_q;

endmodule

// File: tb/tb_clock_24.sv
// tb/tb_clock_24.sv - self-checking bench for clock_24 against a minutes-since-reset model
module tb_clock_24;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   minutes;

  clock_24_if tod_if ();

  clock_24 dut (
    .clk   (clk),
    .reset (reset),
    .tod   (tod_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_hhmm(input string tag, input int h10, input int h1, input int m10, input int m1);
    check({tag, ".hour10"}, 32'(tod_if.hour10), 32'(h10));
    check({tag, ".hour1"},  32'(tod_if.hour1),  32'(h1));
    check({tag, ".min10"},  32'(tod_if.min10),  32'(m10));
    check({tag, ".min1"},   32'(tod_if.min1),   32'(m1));
  endtask

  // Model: time of day is just minutes elapsed since reset, mod one day.
  task automatic check_model(input string tag);
    int tod_min;
    int hh;
    int mm;
    tod_min = minutes % 1440;
    hh = tod_min / 60;
    mm = tod_min % 60;
    check_hhmm(tag, hh / 10, hh % 10, mm / 10, mm % 10);
    check({tag, ".range"}, 32'((tod_if.min1 <= 9) && (tod_if.min10 <= 5) && (tod_if.hour10 <= 2)
                               && !((tod_if.hour10 == 2) && (tod_if.hour1 > 3))), 32'd1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (!reset) minutes++;
    check_model(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    minutes = 0;
    #1;
    check_hhmm("rst_async", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    minutes = 0;
    reset = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_hhmm("reset_held", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_hhmm("released", 0, 0, 0, 0);

    // Two full days from reset, model-checked every edge, milestones by constant.
    for (int e = 1; e <= 2880; e++) begin
      tick("sweep");
      case (e)
        1:    check_hhmm("e1",    0, 0, 0, 1);
        10:   check_hhmm("e10",   0, 0, 1, 0);
        60:   check_hhmm("e60",   0, 1, 0, 0);
        599:  check_hhmm("e599",  0, 9, 5, 9);
        600:  check_hhmm("e600",  1, 0, 0, 0);
        1199: check_hhmm("e1199", 1, 9, 5, 9);
        1200: check_hhmm("e1200", 2, 0, 0, 0);
        1439: check_hhmm("e1439", 2, 3, 5, 9);
        1440: check_hhmm("e1440", 0, 0, 0, 0);
        1441: check_hhmm("e1441", 0, 0, 0, 1);
        2880: check_hhmm("e2880", 0, 0, 0, 0);
        default: ;
      endcase
    end

    // Reset mid-count at 05:37, asserted between edges.
    pulse_reset();
    repeat (337) tick("to0537");
    check_hhmm("t0537", 0, 5, 3, 7);
    #2;
    reset = 1'b1;
    minutes = 0;
    #1;
    check_hhmm("mid_rst_now", 0, 0, 0, 0);
    repeat (3) tick("mid_rst_hold");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_hhmm("mid_rst_rel", 0, 0, 0, 0);
    tick("after_rel");
    check_hhmm("after_rel_c", 0, 0, 0, 1);

    // Random run with occasional asynchronous resets landing at random points.
    for (int c = 0; c < 1500; c++) begin
      tick("rand");
      if ($urandom_range(0, 149) == 0) begin
        #($urandom_range(1, 7));
        reset = 1'b1;
        minutes = 0;
        #1;
        check_hhmm("rand_rst_now", 0, 0, 0, 0);
        repeat ($urandom_range(1, 3)) tick("rand_rst_hold");
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
